// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared state encoding and datapath op encoding for control_unit
package ctrl_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_COUNT_UP,
    S_COUNT_DOWN,
    S_DONE
  } state_e;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
endpackage

// File: rtl/control_unit_if.sv
// control_unit_if: request/flag inputs (start stop dir clr_req z m) and datapath controls/status (op c_ld c_clr busy done)
interface control_unit_if;
  logic start;
  logic stop;
  logic dir;
  logic clr_req;
  logic z;
  logic m;
  logic op;
  logic c_ld;
  logic c_clr;
  logic busy;
  logic done;
  modport master (
    input  start, stop, dir, clr_req, z, m,
    output op, c_ld, c_clr, busy, done
  );
  modport slave (
    output start, stop, dir, clr_req, z, m,
    input  op, c_ld, c_clr, busy, done
  );
endinterface

// File: rtl/tick_gen.sv
// tick_gen: prescaler (clk, rst async active-low, en, sync clr) pulsing tick on every DIV-th enabled cycle
module tick_gen #(
  parameter int DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);
  localparam int W = DIV > 1 ? $clog2(DIV) : 1;
  logic [W-1:0] presc_q, presc_d;
  always_comb begin
    tick = en & (presc_q == W'(DIV - 1));
    presc_d = clr ? '0 : tick ? '0 : en ? presc_q + 1'b1 : presc_q;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) presc_q <= '0;
    else      presc_q <= presc_d;
endmodule

// File: rtl/control_unit.sv
// control_unit: counter control FSM (clk, rst async active-low, bus master) sequencing clear/start/stop/direction with prescaled saturating steps
module control_unit
  import ctrl_pkg::*;
#(
  parameter int DIV = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  control_unit_if.master bus
);
  state_e state_q, state_d;
  logic op_q, op_d, start_q, start_evt, tick, count, flag;
  always_comb begin
    start_evt = bus.start & ~start_q;
    count = (state_q == S_COUNT_UP) | (state_q == S_COUNT_DOWN);
    flag = (state_q == S_COUNT_UP) ? bus.m : bus.z;
    state_d = state_q;
    op_d = op_q;
    case (state_q)
      S_IDLE:
        if (bus.clr_req) state_d = S_CLEAR;
        else if (!bus.stop && start_evt) begin
          state_d = bus.dir ? S_COUNT_DOWN : S_COUNT_UP;
          op_d = bus.dir ? OP_SUB : OP_ADD;
        end
      S_CLEAR: state_d = S_IDLE;
      S_COUNT_UP, S_COUNT_DOWN:
        state_d = bus.clr_req ? S_CLEAR : bus.stop ? S_IDLE : (tick & flag) ? S_DONE : state_q;
      default: state_d = S_IDLE;
    endcase
  end
  // Any state change restarts the prescaler, so each count run begins with a full DIV period.
  tick_gen #(.DIV(DIV)) u_tick (
    .clk (clk),
    .rst (rst),
    .en  (count),
    .clr (state_d != state_q),
    .tick(tick)
  );
  assign bus.op    = op_q;
  assign bus.busy  = count;
  assign bus.c_ld  = count & tick & ~flag & ~bus.clr_req & ~bus.stop;
  assign bus.c_clr = state_q == S_CLEAR;
  assign bus.done  = state_q == S_DONE;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= S_IDLE;
      op_q <= OP_ADD;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      start_q <= bus.start;
    end
endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed checks of control_unit at DIV=4, DIV=2 and DIV=1
module tb_control_unit;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0, stop = 1'b0, dir = 1'b0, clr_req = 1'b0, z = 1'b0, m = 1'b0;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  control_unit_if u4_if ();
  control_unit_if u2_if ();
  control_unit_if u1_if ();
  assign u4_if.start = start;
  assign u4_if.stop = stop;
  assign u4_if.dir = dir;
  assign u4_if.clr_req = clr_req;
  assign u4_if.z = z;
  assign u4_if.m = m;
  assign u2_if.start = start;
  assign u2_if.stop = stop;
  assign u2_if.dir = dir;
  assign u2_if.clr_req = clr_req;
  assign u2_if.z = z;
  assign u2_if.m = m;
  assign u1_if.start = start;
  assign u1_if.stop = stop;
  assign u1_if.dir = dir;
  assign u1_if.clr_req = clr_req;
  assign u1_if.z = z;
  assign u1_if.m = m;
  control_unit #(.DIV(4)) u4 (.clk(clk), .rst(rst), .bus(u4_if));
  control_unit #(.DIV(2)) u2 (.clk(clk), .rst(rst), .bus(u2_if));
  control_unit #(.DIV(1)) u1 (.clk(clk), .rst(rst), .bus(u1_if));
  task automatic chk(input string tag, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic settle_idle();
    @(negedge clk); stop = 1'b1;
    @(negedge clk); stop = 1'b0;
  endtask
  initial begin
    @(negedge clk); #1;
    chk("rst_busy", u4_if.busy, 1'b0);
    chk("rst_c_ld", u4_if.c_ld, 1'b0);
    chk("rst_c_clr", u4_if.c_clr, 1'b0);
    chk("rst_done", u4_if.done, 1'b0);
    chk("rst_op", u4_if.op, 1'b0);
    @(negedge clk); rst = 1'b1;
    @(negedge clk); start = 1'b1; #1;
    chk("up_c0_busy", u4_if.busy, 1'b0);
    for (int k = 1; k <= 13; k++) begin
      @(negedge clk); start = 1'b0;
      if (k == 5) dir = 1'b1;
      #1;
      chk($sformatf("up_c%0d_busy", k), u4_if.busy, 1'b1);
      chk($sformatf("up_c%0d_c_ld", k), u4_if.c_ld, k % 4 == 0);
      chk($sformatf("up_c%0d_op", k), u4_if.op, 1'b0);
    end
    @(negedge clk); stop = 1'b1; #1;
    chk("stop_c_ld", u4_if.c_ld, 1'b0);
    chk("stop_busy", u4_if.busy, 1'b1);
    for (int k = 15; k <= 20; k++) begin
      @(negedge clk); stop = 1'b0; #1;
      chk($sformatf("stopped_c%0d_busy", k), u4_if.busy, 1'b0);
      chk($sformatf("stopped_c%0d_c_ld", k), u4_if.c_ld, 1'b0);
    end
    dir = 1'b0;
    settle_idle();
    @(negedge clk); start = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk); start = 1'b0;
      if (k == 6) m = 1'b1;
      #1;
      chk($sformatf("sat_c%0d_busy", k), u4_if.busy, k <= 8);
      chk($sformatf("sat_c%0d_c_ld", k), u4_if.c_ld, k == 4);
      chk($sformatf("sat_c%0d_done", k), u4_if.done, k == 9);
    end
    m = 1'b0;
    settle_idle();
    dir = 1'b1; z = 1'b1;
    @(negedge clk); start = 1'b1; #1;
    chk("dn_c0_busy", u1_if.busy, 1'b0);
    @(negedge clk); start = 1'b0; #1;
    chk("dn_c1_op", u1_if.op, 1'b1);
    chk("dn_c1_busy", u1_if.busy, 1'b1);
    chk("dn_c1_c_ld", u1_if.c_ld, 1'b0);
    @(negedge clk); #1;
    chk("dn_c2_done", u1_if.done, 1'b1);
    chk("dn_c2_c_ld", u1_if.c_ld, 1'b0);
    @(negedge clk); #1;
    chk("dn_c3_done", u1_if.done, 1'b0);
    dir = 1'b0; z = 1'b0;
    repeat (4) settle_idle();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk); #1;
    chk("clr_c2_c_ld", u2_if.c_ld, 1'b1);
    @(negedge clk); #1;
    chk("clr_c3_c_ld", u2_if.c_ld, 1'b0);
    @(negedge clk); clr_req = 1'b1; stop = 1'b1; start = 1'b1; #1;
    chk("clr_c4_c_ld", u2_if.c_ld, 1'b0);
    @(negedge clk); clr_req = 1'b0; stop = 1'b0; #1;
    chk("clr_c5_c_clr", u2_if.c_clr, 1'b1);
    chk("clr_c5_busy", u2_if.busy, 1'b0);
    chk("clr_c5_c_ld", u2_if.c_ld, 1'b0);
    for (int k = 6; k <= 8; k++) begin
      @(negedge clk); #1;
      chk($sformatf("clr_c%0d_c_clr", k), u2_if.c_clr, 1'b0);
      chk($sformatf("clr_c%0d_busy", k), u2_if.busy, 1'b0);
    end
    start = 1'b0;
    repeat (4) settle_idle();
    @(negedge clk); start = 1'b1;
    @(negedge clk); #1;
    chk("held_c1_busy", u4_if.busy, 1'b1);
    @(negedge clk); stop = 1'b1;
    for (int k = 3; k <= 6; k++) begin
      @(negedge clk); stop = 1'b0; #1;
      chk($sformatf("held_c%0d_busy", k), u4_if.busy, 1'b0);
    end
    @(negedge clk); start = 1'b0; dir = 1'b1;
    @(negedge clk); start = 1'b1;
    @(negedge clk); #1;
    chk("restart_busy", u4_if.busy, 1'b1);
    chk("restart_op", u4_if.op, 1'b1);
    repeat (3) @(negedge clk);
    #1;
    chk("pre_rst_c_ld", u4_if.c_ld, 1'b1);
    rst = 1'b0; #1;
    chk("mid_rst_busy", u4_if.busy, 1'b0);
    chk("mid_rst_c_ld", u4_if.c_ld, 1'b0);
    chk("mid_rst_op", u4_if.op, 1'b0);
    start = 1'b0; dir = 1'b0;
    @(negedge clk); rst = 1'b1;
    repeat (3) begin
      @(negedge clk); #1;
      chk("post_rst_busy", u4_if.busy, 1'b0);
    end
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; #1;
    chk("post_rst_start_busy", u4_if.busy, 1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
